// File: rtl/axil_apb_pkg.sv
// Shared types and response codes for the AXI4-Lite to APB bridge.
package axil_apb_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WRESP, RRESP} state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axil_req_hold.sv
// One-deep valid/ready holding register; ready is registered so it reads 0 while in reset.
module axil_req_hold
  import axil_apb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clear,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);
  logic             r_full;
  logic             r_ready;
  logic [WIDTH-1:0] r_data;
  logic             w_take;
  logic             w_full_nxt;

  assign w_take = i_valid && r_ready;

  always_comb begin
    w_full_nxt = r_full;
    if (w_take)
      w_full_nxt = 1'b1;
    else if (i_clear)
      w_full_nxt = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_full  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_full  <= w_full_nxt;
      r_ready <= !w_full_nxt;
    end
  end

  // Payload needs no reset: it is only observed while r_full is set.
  always_ff @(posedge i_clk) begin
    if (w_take)
      r_data <= i_data;
  end

  assign o_ready = r_ready;
  assign o_full  = r_full;
  assign o_data  = r_data;
endmodule

// File: rtl/axil_apb_bridge.sv
// AXI4-Lite slave to APB3 master bridge; one APB transfer in flight, read/write ties alternate.
module axil_apb_bridge
  import axil_apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [ADDR_WIDTH-1:0] i_s_axi_awaddr,
  input  logic                  i_s_axi_awvalid,
  output logic                  o_s_axi_awready,
  input  logic [DATA_WIDTH-1:0] i_s_axi_wdata,
  input  logic                  i_s_axi_wvalid,
  output logic                  o_s_axi_wready,
  output logic [1:0]            o_s_axi_bresp,
  output logic                  o_s_axi_bvalid,
  input  logic                  i_s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] i_s_axi_araddr,
  input  logic                  i_s_axi_arvalid,
  output logic                  o_s_axi_arready,
  output logic [DATA_WIDTH-1:0] o_s_axi_rdata,
  output logic [1:0]            o_s_axi_rresp,
  output logic                  o_s_axi_rvalid,
  input  logic                  i_s_axi_rready,
  output logic                  o_psel,
  output logic                  o_penable,
  output logic                  o_pwrite,
  output logic [ADDR_WIDTH-1:0] o_paddr,
  output logic [DATA_WIDTH-1:0] o_pwdata,
  input  logic                  i_pready,
  input  logic [DATA_WIDTH-1:0] i_prdata,
  input  logic                  i_pslverr
);
  localparam int            TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                r_state;
  logic                  r_rd_first;
  logic                  r_psel, r_penable, r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic                  r_bvalid, r_rvalid;
  logic [1:0]            r_bresp, r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [TW-1:0]         r_tcnt;

  logic                  w_aw_full, w_w_full, w_ar_full;
  logic [ADDR_WIDTH-1:0] w_awaddr, w_araddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_wr_pend, w_rd_pend;
  logic                  w_timeout, w_done, w_clr_wr, w_clr_rd;
  logic [1:0]            w_resp;

  axil_req_hold #(.WIDTH(ADDR_WIDTH)) u_aw (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_s_axi_awvalid), .o_ready(o_s_axi_awready),
    .i_data(i_s_axi_awaddr), .i_clear(w_clr_wr), .o_full(w_aw_full), .o_data(w_awaddr));
  axil_req_hold #(.WIDTH(DATA_WIDTH)) u_w (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_s_axi_wvalid), .o_ready(o_s_axi_wready),
    .i_data(i_s_axi_wdata), .i_clear(w_clr_wr), .o_full(w_w_full), .o_data(w_wdata));
  axil_req_hold #(.WIDTH(ADDR_WIDTH)) u_ar (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_s_axi_arvalid), .o_ready(o_s_axi_arready),
    .i_data(i_s_axi_araddr), .i_clear(w_clr_rd), .o_full(w_ar_full), .o_data(w_araddr));

  assign w_wr_pend = w_aw_full && w_w_full;
  assign w_rd_pend = w_ar_full;
  assign w_timeout = (TIMEOUT_CYCLES > 0) && !i_pready && (r_tcnt == TLAST);
  assign w_done    = (r_state == ACCESS) && (i_pready || w_timeout);
  assign w_clr_wr  = w_done && r_pwrite;
  assign w_clr_rd  = w_done && !r_pwrite;
  assign w_resp    = (w_timeout || i_pslverr) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_rd_first <= 1'b1;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
      r_tcnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // The op started here loses the next read/write tie.
          if (w_rd_pend && (r_rd_first || !w_wr_pend)) begin
            r_state    <= SETUP;
            r_psel     <= 1'b1;
            r_pwrite   <= 1'b0;
            r_paddr    <= w_araddr;
            r_rd_first <= 1'b0;
          end else if (w_wr_pend) begin
            r_state    <= SETUP;
            r_psel     <= 1'b1;
            r_pwrite   <= 1'b1;
            r_paddr    <= w_awaddr;
            r_pwdata   <= w_wdata;
            r_rd_first <= 1'b1;
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
          r_tcnt    <= '0;
        end
        ACCESS: begin
          if (w_done) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            if (r_pwrite) begin
              r_state  <= WRESP;
              r_bvalid <= 1'b1;
              r_bresp  <= w_resp;
            end else begin
              r_state  <= RRESP;
              r_rvalid <= 1'b1;
              r_rresp  <= w_resp;
              r_rdata  <= w_timeout ? '0 : i_prdata;
            end
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        WRESP: begin
          if (i_s_axi_bready) begin
            r_state  <= IDLE;
            r_bvalid <= 1'b0;
          end
        end
        RRESP: begin
          if (i_s_axi_rready) begin
            r_state  <= IDLE;
            r_rvalid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_psel         = r_psel;
  assign o_penable      = r_penable;
  assign o_pwrite       = r_pwrite;
  assign o_paddr        = r_paddr;
  assign o_pwdata       = r_pwdata;
  assign o_s_axi_bvalid = r_bvalid;
  assign o_s_axi_bresp  = r_bresp;
  assign o_s_axi_rvalid = r_rvalid;
  assign o_s_axi_rresp  = r_rresp;
  assign o_s_axi_rdata  = r_rdata;
endmodule

// File: tb/tb_axil_apb_bridge.sv
// Directed bench for axil_apb_bridge: latency, ordering, errors, timeout, backpressure and reset.
module tb_axil_apb_bridge;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr, wdata, araddr, paddr, pwdata, rdata, prdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        psel, penable, pwrite, pready, pslverr;
  int          n_checks = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  axil_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_s_axi_awaddr(awaddr), .i_s_axi_awvalid(awvalid), .o_s_axi_awready(awready),
    .i_s_axi_wdata(wdata), .i_s_axi_wvalid(wvalid), .o_s_axi_wready(wready),
    .o_s_axi_bresp(bresp), .o_s_axi_bvalid(bvalid), .i_s_axi_bready(bready),
    .i_s_axi_araddr(araddr), .i_s_axi_arvalid(arvalid), .o_s_axi_arready(arready),
    .o_s_axi_rdata(rdata), .o_s_axi_rresp(rresp), .o_s_axi_rvalid(rvalid), .i_s_axi_rready(rready),
    .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite), .o_paddr(paddr), .o_pwdata(pwdata),
    .i_pready(pready), .i_prdata(prdata), .i_pslverr(pslverr));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present AW+W and/or AR together and drop each valid after its handshake edge.
  task automatic send(input bit dw, input logic [31:0] wa, input logic [31:0] wd,
                      input bit dr, input logic [31:0] ra);
    bit hs_aw, hs_w, hs_ar;
    awaddr = wa; wdata = wd; araddr = ra;
    awvalid = dw; wvalid = dw; arvalid = dr;
    for (int i = 0; i < 20; i++) begin
      if (!awvalid && !wvalid && !arvalid) break;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      hs_ar = arvalid && arready;
      tick();
      if (hs_aw) awvalid = 1'b0;
      if (hs_w)  wvalid  = 1'b0;
      if (hs_ar) arvalid = 1'b0;
    end
    check("send_handshake", {awvalid, wvalid, arvalid}, 3'b000);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
  endtask

  task automatic apb_expect(input string tag, input bit wr, input logic [31:0] a,
                            input logic [31:0] d);
    int n = 0;
    while (!psel && n < 30) begin tick(); n++; end
    check({tag, "_psel"}, psel, 1'b1);
    check({tag, "_setup_penable"}, penable, 1'b0);
    check({tag, "_pwrite"}, pwrite, wr);
    check({tag, "_paddr"}, paddr, a);
    if (wr) check({tag, "_pwdata"}, pwdata, d);
    tick();
    check({tag, "_access"}, {psel, penable}, 2'b11);
  endtask

  task automatic b_expect(input string tag, input logic [1:0] resp);
    int n = 0;
    while (!bvalid && n < 30) begin tick(); n++; end
    check({tag, "_bvalid"}, bvalid, 1'b1);
    check({tag, "_bresp"}, bresp, resp);
    tick();
    check({tag, "_bdone"}, bvalid, 1'b0);
  endtask

  task automatic r_expect(input string tag, input logic [1:0] resp, input logic [31:0] d);
    int n = 0;
    while (!rvalid && n < 30) begin tick(); n++; end
    check({tag, "_rvalid"}, rvalid, 1'b1);
    check({tag, "_rresp"}, rresp, resp);
    check({tag, "_rdata"}, rdata, d);
    tick();
    check({tag, "_rdone"}, rvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    awaddr = '0; wdata = '0; araddr = '0; prdata = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1; pready = 1'b1; pslverr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {psel, penable, pwrite, awready, wready, arready, bvalid, rvalid, bresp, rresp}, 12'h000);
    check("rst_data", {paddr, pwdata}, 64'h0);
    check("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", {awready, wready, arready}, 3'b111);

    // 1: write then read back, with exact cycle latency
    send(1'b1, 32'h44A0_0000, 32'h0000_0123, 1'b0, 32'h0);
    check("t1_wr_idle", psel, 1'b0);
    tick();
    check("t1_wr_setup", {psel, penable, pwrite}, 3'b101);
    check("t1_wr_paddr", paddr, 32'h44A0_0000);
    check("t1_wr_pwdata", pwdata, 32'h0000_0123);
    tick();
    check("t1_wr_access", {psel, penable}, 2'b11);
    tick();
    check("t1_wr_resp", {bvalid, bresp, psel, penable}, 5'b10000);
    check("t1_wr_ready_back", {awready, wready}, 2'b11);
    tick();
    check("t1_wr_bdone", bvalid, 1'b0);
    prdata = 32'h0000_0123;
    send(1'b0, 32'h0, 32'h0, 1'b1, 32'h44A0_0000);
    tick();
    check("t1_rd_setup", {psel, penable, pwrite}, 3'b100);
    check("t1_rd_paddr", paddr, 32'h44A0_0000);
    tick();
    check("t1_rd_access", {psel, penable}, 2'b11);
    tick();
    check("t1_rd_resp", {rvalid, rresp, psel}, 4'b1000);
    check("t1_rd_rdata", rdata, 32'h0000_0123);
    tick();
    check("t1_rd_rdone", rvalid, 1'b0);

    // 2: W arrives five cycles ahead of AW
    wdata = 32'h0000_1234; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("t2_w_taken", wready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_no_psel", psel, 1'b0);
    end
    check("t2_aw_ready", awready, 1'b1);
    awaddr = 32'h44A0_000C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    apb_expect("t2", 1'b1, 32'h44A0_000C, 32'h0000_1234);
    b_expect("t2", 2'b00);
    tick();
    check("t2_single_psel", psel, 1'b0);

    // 3: read/write tie after reset goes read-first, then alternates
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    prdata = 32'h0000_0020;
    send(1'b1, 32'h44A0_0010, 32'h0000_A5A5, 1'b1, 32'h44A0_0020);
    apb_expect("t3_rd", 1'b0, 32'h44A0_0020, 32'h0);
    r_expect("t3_rd", 2'b00, 32'h0000_0020);
    apb_expect("t3_wr", 1'b1, 32'h44A0_0010, 32'h0000_A5A5);
    b_expect("t3_wr", 2'b00);
    prdata = 32'h0000_0024;
    send(1'b0, 32'h0, 32'h0, 1'b1, 32'h44A0_0024);
    apb_expect("t3b_rd", 1'b0, 32'h44A0_0024, 32'h0);
    r_expect("t3b_rd", 2'b00, 32'h0000_0024);
    prdata = 32'h0000_0028;
    send(1'b1, 32'h44A0_0014, 32'h0000_5A5A, 1'b1, 32'h44A0_0028);
    apb_expect("t3c_wr", 1'b1, 32'h44A0_0014, 32'h0000_5A5A);
    b_expect("t3c_wr", 2'b00);
    apb_expect("t3c_rd", 1'b0, 32'h44A0_0028, 32'h0);
    r_expect("t3c_rd", 2'b00, 32'h0000_0028);

    // 4: slave error on write and read, then a clean transfer
    pslverr = 1'b1;
    send(1'b1, 32'h44A0_0030, 32'h0000_BEEF, 1'b0, 32'h0);
    apb_expect("t4_wr", 1'b1, 32'h44A0_0030, 32'h0000_BEEF);
    b_expect("t4_wr", 2'b10);
    prdata = 32'h0000_0055;
    send(1'b0, 32'h0, 32'h0, 1'b1, 32'h44A0_0034);
    apb_expect("t4_rd", 1'b0, 32'h44A0_0034, 32'h0);
    r_expect("t4_rd", 2'b10, 32'h0000_0055);
    pslverr = 1'b0;
    prdata = 32'h0000_0077;
    send(1'b0, 32'h0, 32'h0, 1'b1, 32'h44A0_0038);
    apb_expect("t4_ok", 1'b0, 32'h44A0_0038, 32'h0);
    r_expect("t4_ok", 2'b00, 32'h0000_0077);

    // 5: slave never ready -> forced SLVERR after 16 ACCESS cycles
    pready = 1'b0;
    prdata = 32'hDEAD_BEEF;
    send(1'b0, 32'h0, 32'h0, 1'b1, 32'h44A0_0040);
    apb_expect("t5", 1'b0, 32'h44A0_0040, 32'h0);
    n = 1;
    while (penable && n < 40) begin
      tick();
      if (penable) n++;
    end
    check("t5_access_cycles", n, 16);
    check("t5_resp", {rvalid, rresp, psel}, 4'b1100);
    check("t5_rdata", rdata, 32'h0);
    tick();
    check("t5_rdone", rvalid, 1'b0);
    pready = 1'b1;

    // 6: B backpressure, then reset during ACCESS
    bready = 1'b0;
    send(1'b1, 32'h44A0_0050, 32'h0000_0006, 1'b0, 32'h0);
    apb_expect("t6_wr", 1'b1, 32'h44A0_0050, 32'h0000_0006);
    n = 0;
    while (!bvalid && n < 30) begin tick(); n++; end
    check("t6_bvalid", bvalid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6_bstable", {bvalid, bresp}, 3'b100);
    end
    bready = 1'b1;
    tick();
    check("t6_bdone", bvalid, 1'b0);
    pready = 1'b0;
    send(1'b0, 32'h0, 32'h0, 1'b1, 32'h44A0_0060);
    apb_expect("t6_rd", 1'b0, 32'h44A0_0060, 32'h0);
    send(1'b1, 32'h44A0_0064, 32'h0000_0064, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ctrl", {psel, penable, pwrite, awready, wready, arready, bvalid, rvalid, bresp, rresp}, 12'h000);
    check("t6_rst_data", {paddr, pwdata}, 64'h0);
    check("t6_rst_rdata", rdata, 32'h0);
    pready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_ready_back", {awready, wready, arready}, 3'b111);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_discarded", {psel, bvalid, rvalid}, 3'b000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
